io_bus_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the memory-mapped I/O bus shared by data memory, the factorial accelerator and the GPIO block.
- Master 0 is the MIPS core data port; master 1 is a secondary requester (DMA or debug loader).
- Grants one single-beat transaction per cycle using round-robin.
- Decodes the granted address into per-slave write strobes and a read select, and returns registered read data to the granted master.

---
 rtl/io_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_io_bus_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory-mapped I/O bus.
// One single-beat transaction per cycle, decoded to DMEM/FACT/GPIO.
module io_bus_arbiter #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic          wem,
    output logic          we1,
    output logic          we2,
    input  logic [DW-1:0] dmem_rd,
    input  logic [DW-1:0] fact_rd,
    input  logic [DW-1:0] gpio_rd,
    output logic          dec_err
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_gnt;
    logic          last_gnt_nxt;
    logic          sel0;
    logic          sel1;
    logic          active;
    logic          bus_we;
    logic          hit_dmem;
    logic          hit_fact;
    logic          hit_gpio;
    logic          mapped;
    logic [DW-1:0] rd_mux;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // A tie goes to the master that did not win the previous grant.
    always_comb begin
        state_nxt    = IDLE;
        last_gnt_nxt = last_gnt;
        if (m0_req && m1_req) begin
            state_nxt = last_gnt ? GNT0 : GNT1;
        end else if (m0_req) begin
            state_nxt = GNT0;
        end else if (m1_req) begin
            state_nxt = GNT1;
        end
        if (state_nxt == GNT0) begin
            last_gnt_nxt = 1'b0;
        end else if (state_nxt == GNT1) begin
            last_gnt_nxt = 1'b1;
        end
    end

    // Reset aborts a grant in progress so nothing is written that cycle.
    assign sel0   = (state == GNT0) && !reset;
    assign sel1   = (state == GNT1) && !reset;
    assign active = sel0 || sel1;
    assign m0_gnt = sel0;
    assign m1_gnt = sel1;

    always_comb begin
        bus_addr  = '0;
        bus_wdata = '0;
        bus_we    = 1'b0;
        if (sel0) begin
            bus_addr  = m0_addr;
            bus_wdata = m0_wdata;
            bus_we    = m0_we;
        end else if (sel1) begin
            bus_addr  = m1_addr;
            bus_wdata = m1_wdata;
            bus_we    = m1_we;
        end
    end

    assign hit_dmem = (bus_addr >> 8) == '0;
    assign hit_fact = (bus_addr >> 4) == AW'(32'h80);
    assign hit_gpio = (bus_addr >> 4) == AW'(32'h90);
    assign mapped   = hit_dmem || hit_fact || hit_gpio;

    assign wem = active && bus_we && hit_dmem;
    assign we1 = active && bus_we && hit_fact;
    assign we2 = active && bus_we && hit_gpio;

    always_comb begin
        rd_mux = '0;
        if (hit_dmem) begin
            rd_mux = dmem_rd;
        end else if (hit_fact) begin
            rd_mux = fact_rd;
        end else if (hit_gpio) begin
            rd_mux = gpio_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            dec_err   <= 1'b0;
        end else begin
            m0_rvalid <= sel0 && !m0_we;
            m1_rvalid <= sel1 && !m1_we;
            dec_err   <= active && !mapped;
            if (sel0 && !m0_we) begin
                m0_rdata <= rd_mux;
            end
            if (sel1 && !m1_we) begin
                m1_rdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: grants, decode, read return,
// decode errors and reset behaviour.
module tb_io_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        wem;
    logic        we1;
    logic        we2;
    logic [31:0] dmem_rd;
    logic [31:0] fact_rd;
    logic [31:0] gpio_rd;
    logic        dec_err;

    int errors = 0;
    int checks = 0;

    io_bus_arbiter #(.DW(32), .AW(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .wem(wem), .we1(we1), .we2(we2),
        .dmem_rd(dmem_rd), .fact_rd(fact_rd), .gpio_rd(gpio_rd),
        .dec_err(dec_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        dmem_rd = '0; fact_rd = '0; gpio_rd = '0;
        step();
        step();
        reset = 1'b0;
        settle();
        check("rst_gnt0", {31'b0, m0_gnt}, 32'd0);
        check("rst_gnt1", {31'b0, m1_gnt}, 32'd0);
        check("rst_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'd0);
        check("rst_rdata0", m0_rdata, 32'd0);
        check("rst_rdata1", m1_rdata, 32'd0);
        check("rst_dec_err", {31'b0, dec_err}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);

        // m0 write to GPIO
        m0_req = 1; m0_we = 1; m0_addr = 32'h900; m0_wdata = 32'hA5;
        settle();
        check("w0_nogntyet", {31'b0, m0_gnt}, 32'd0);
        step();
        m0_req = 0;
        settle();
        check("w0_gnt", {31'b0, m0_gnt}, 32'd1);
        check("w0_strobes", {29'b0, wem, we1, we2}, 32'b001);
        check("w0_wdata", bus_wdata, 32'hA5);
        check("w0_addr", bus_addr, 32'h900);
        step();
        check("w0_idle_gnt", {31'b0, m0_gnt}, 32'd0);
        check("w0_idle_str", {29'b0, wem, we1, we2}, 32'd0);
        check("w0_idle_addr", bus_addr, 32'd0);
        check("w0_dec_err", {31'b0, dec_err}, 32'd0);

        // both masters read continuously after a fresh reset
        reset = 1; step(); reset = 0;
        m0_we = 0; m0_addr = 32'h004;
        m1_we = 0; m1_addr = 32'h808;
        dmem_rd = 32'h11; fact_rd = 32'h22;
        m0_req = 1; m1_req = 1;
        step();
        check("rr_g1", {30'b0, m0_gnt, m1_gnt}, 32'b10);
        check("rr_a1", bus_addr, 32'h004);
        step();
        check("rr_g2", {30'b0, m0_gnt, m1_gnt}, 32'b01);
        check("rr_a2", bus_addr, 32'h808);
        check("rr_rv0", {31'b0, m0_rvalid}, 32'd1);
        check("rr_rd0", m0_rdata, 32'h11);
        step();
        check("rr_g3", {30'b0, m0_gnt, m1_gnt}, 32'b10);
        check("rr_rv1", {30'b0, m0_rvalid, m1_rvalid}, 32'b01);
        check("rr_rd1", m1_rdata, 32'h22);
        m0_req = 0; m1_req = 0;
        step();
        check("rr_idle", {30'b0, m0_gnt, m1_gnt}, 32'd0);
        check("rr_rv0b", {30'b0, m0_rvalid, m1_rvalid}, 32'b10);
        step();
        check("rr_rvoff", {30'b0, m0_rvalid, m1_rvalid}, 32'd0);
        check("rr_hold0", m0_rdata, 32'h11);

        // m1 write then read back-to-back
        m1_req = 1; m1_we = 1; m1_addr = 32'h004; m1_wdata = 32'h1234;
        dmem_rd = 32'h5A5A;
        step();
        check("bb_gnt_w", {31'b0, m1_gnt}, 32'd1);
        check("bb_strobes", {29'b0, wem, we1, we2}, 32'b100);
        check("bb_wdata", bus_wdata, 32'h1234);
        step();
        m1_we = 0; m1_req = 0;
        settle();
        check("bb_gnt_r", {31'b0, m1_gnt}, 32'd1);
        check("bb_rd_nostr", {29'b0, wem, we1, we2}, 32'd0);
        step();
        check("bb_rvalid", {31'b0, m1_rvalid}, 32'd1);
        check("bb_rdata", m1_rdata, 32'h5A5A);

        // m0 unmapped read
        m0_req = 1; m0_we = 0; m0_addr = 32'h4000;
        step();
        m0_req = 0;
        settle();
        check("ur_gnt", {30'b0, m0_gnt, m1_gnt}, 32'b10);
        check("ur_strobes", {29'b0, wem, we1, we2}, 32'd0);
        step();
        check("ur_rvalid", {31'b0, m0_rvalid}, 32'd1);
        check("ur_rdata", m0_rdata, 32'd0);
        check("ur_dec_err", {31'b0, dec_err}, 32'd1);
        check("ur_m1", {29'b0, m1_gnt, m1_rvalid, wem}, 32'd0);
        check("ur_m1_rdata", m1_rdata, 32'h5A5A);
        step();
        check("ur_dec_off", {31'b0, dec_err}, 32'd0);

        // m0 unmapped write is dropped
        m0_req = 1; m0_we = 1; m0_addr = 32'h810; m0_wdata = 32'h77;
        step();
        m0_req = 0;
        settle();
        check("uw_strobes", {29'b0, wem, we1, we2}, 32'd0);
        step();
        check("uw_dec_err", {31'b0, dec_err}, 32'd1);
        check("uw_rvalid", {31'b0, m0_rvalid}, 32'd0);

        // reset in the middle of an m1 GNT write
        m1_req = 1; m1_we = 1; m1_addr = 32'h904; m1_wdata = 32'h9;
        step();
        check("rg_we2", {29'b0, wem, we1, we2}, 32'b001);
        m0_req = 1; m0_we = 0; m0_addr = 32'h004;
        reset = 1;
        settle();
        check("rg_abort", {28'b0, m1_gnt, wem, we1, we2}, 32'd0);
        step();
        reset = 0;
        m1_we = 0;
        settle();
        check("rg_idle", {28'b0, m0_gnt, m1_gnt, we2, wem}, 32'd0);
        check("rg_rdata1", m1_rdata, 32'd0);
        check("rg_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'd0);
        step();
        check("rg_first", {30'b0, m0_gnt, m1_gnt}, 32'b10);
        m0_req = 0;
        step();
        check("rg_second", {30'b0, m0_gnt, m1_gnt}, 32'b01);
        m1_req = 0;
        step();

        // m1 alone, twice: no lost cycle although last_gnt is m1
        m1_req = 1; m1_we = 0; m1_addr = 32'h900; gpio_rd = 32'hBEEF;
        step();
        check("s1_gnt", {30'b0, m0_gnt, m1_gnt}, 32'b01);
        m1_req = 0;
        step();
        check("s1_rdata", m1_rdata, 32'hBEEF);
        m1_req = 1;
        step();
        check("s1_again", {30'b0, m0_gnt, m1_gnt}, 32'b01);
        m1_req = 0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
